// File: rtl/seg7_pkg.sv
// Shared segment codes and sizing helpers for the seven-segment scan driver.
package seg7_pkg;

  // Bit order is {g,f,e,d,c,b,a}, active-high before any polarity inversion.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b1111100;
  localparam seg_t SEG_C     = 7'b0111001;
  localparam seg_t SEG_D     = 7'b1011110;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_F     = 7'b1110001;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // Digit index width; a single-digit bank still needs one bit.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with optional hex glyphs and forced blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  input  logic       blank,
  output seg_t       code
);

  always_comb begin
    // NOTE: default assignment first so every path drives code and no latch is inferred.
    code = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0: code = SEG_0;
        4'h1: code = SEG_1;
        4'h2: code = SEG_2;
        4'h3: code = SEG_3;
        4'h4: code = SEG_4;
        4'h5: code = SEG_5;
        4'h6: code = SEG_6;
        4'h7: code = SEG_7;
        4'h8: code = SEG_8;
        4'h9: code = SEG_9;
        4'hA: code = hex_en ? SEG_A : SEG_BLANK;
        4'hB: code = hex_en ? SEG_B : SEG_BLANK;
        4'hC: code = hex_en ? SEG_C : SEG_BLANK;
        4'hD: code = hex_en ? SEG_D : SEG_BLANK;
        4'hE: code = hex_en ? SEG_E : SEG_BLANK;
        4'hF: code = hex_en ? SEG_F : SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: double-buffered value, one digit per
// SCAN_DIV clocks, leading-zero blanking and per-output polarity control.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit HEX_EN   = 1'b0,
  parameter bit SEG_INV  = 1'b0,
  parameter bit DIG_INV  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seven,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_INV}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_INV}};

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend, disp;
  logic [DIGITS-1:0]   pend_dp, disp_dp;
  logic                pend_v;

  logic tick, wrap, commit;

  assign tick   = enable && (pre == PRE_LAST);
  assign wrap   = tick && (idx == IDX_LAST);
  // The display buffer may only change at a frame boundary or while scanning is stopped.
  assign commit = wrap || !enable;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (!enable) begin
      pre <= '0;
      idx <= '0;
    end else if (tick) begin
      pre <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      pend_dp <= '0;
      pend_v  <= 1'b0;
      disp    <= '0;
      disp_dp <= '0;
    end else begin
      if (load) begin
        pend    <= bcd_in;
        pend_dp <= dp_in;
      end
      // A load landing on a commit edge bypasses the pending buffer.
      if (commit && load) begin
        disp    <= bcd_in;
        disp_dp <= dp_in;
      end else if (commit && pend_v) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
      pend_v <= !commit && (load || pend_v);
    end
  end

  logic [3:0]        nib;
  logic              dp_sel;
  logic              blank;
  logic              upper_zero;
  logic [DIGITS-1:0] sel;
  seg_t              code;

  // Walk from the most significant digit down so upper_zero means "this and all higher nibbles are 0".
  always_comb begin
    nib        = '0;
    dp_sel     = 1'b0;
    blank      = 1'b0;
    upper_zero = 1'b1;
    sel        = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib    = disp[4*i +: 4];
        dp_sel = disp_dp[i];
        blank  = blank_lz && (i != 0) && upper_zero;
        sel[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .nibble (nib),
    .hex_en (HEX_EN),
    .blank  (blank),
    .code   (code)
  );

  // Segments and select share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seven      <= SEG_OFF;
      dp         <= SEG_INV;
      digit_en   <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (enable) begin
        seven    <= code ^ SEG_OFF;
        dp       <= dp_sel ^ SEG_INV;
        digit_en <= sel ^ DIG_OFF;
      end else begin
        seven    <= SEG_OFF;
        dp       <= SEG_INV;
        digit_en <= DIG_OFF;
      end
    end
  end

endmodule
